muldiv_unit: RTL

Iterative multiply/divide unit in the EX stage, alongside the ALU; it implements the MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. It takes the same two register operands the ALU receives (DataA = rs, DataB = rt) and holds results in architectural HI/LO registers. MFHI and MFLO read those registers through the hi/lo outputs. The pipeline control stalls issue while busy is high.

---
 rtl/muldiv_unit_if.sv | 14 +
 rtl/muldiv_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, DataA, DataB, input busy, done, hi, lo);
  modport slave  (input start, op, DataA, DataB, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic         clk,
  input logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        count;
  // Shared working register: multiply {acc_hi, multiplier}, divide {remainder, quotient}
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH-1:0]     b;
  logic                 is_div, neg_p, neg_q, neg_r, dz;
  logic                 accept, issue, wr_hi, wr_lo, step, finish;
  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quo, rem;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: one issue, WIDTH iterations, one fix-up cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode; starts outside IDLE are dropped here
  always_comb begin
    accept = (state == IDLE) && bus.start;
    issue  = accept && !bus.op[2];
    wr_hi  = accept && (bus.op == 3'b100);
    wr_lo  = accept && (bus.op == 3'b101);
    step   = (state == CALC);
    finish = (state == FIX);
  end

  // Signed ops (op[0]=0) work on magnitudes; the signs are recorded at issue
  always_comb begin
    sa    = !bus.op[0] && bus.DataA[WIDTH-1];
    sb    = !bus.op[0] && bus.DataB[WIDTH-1];
    mag_a = sa ? -bus.DataA : bus.DataA;
    mag_b = sb ? -bus.DataB : bus.DataB;
  end

  // One shift-add or restoring shift-subtract step, plus final sign correction
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, p[WIDTH-1:1]};
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  p[WIDTH-2:0], 1'b1};
    prod      = neg_p ? -p : p;
    quo       = dz ? {WIDTH{1'b1}} : (neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
    rem       = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  end

  // Datapath, counter and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      p      <= '0;
      b      <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= finish;
      if (issue) begin
        is_div <= bus.op[1];
        p      <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
        b      <= bus.op[1] ? mag_b : mag_a;
        neg_p  <= sa ^ sb;
        // A zero divisor keeps the all-ones quotient unsigned
        neg_q  <= (sa ^ sb) && (bus.DataB != '0);
        neg_r  <= sa;
        dz     <= (bus.DataB == '0);
        count  <= '0;
      end else if (step) begin
        count <= count + 1'b1;
        p     <= is_div ? div_next : mul_next;
      end
      if (finish) begin
        hi_q <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo_q <= is_div ? quo : prod[WIDTH-1:0];
      end else begin
        if (wr_hi) hi_q <= bus.DataA;
        if (wr_lo) lo_q <= bus.DataA;
      end
    end
  end
endmodule
